// File: rtl/bdp_pkg.sv
// Shared definitions for the bit-plane scheduler slice.
//   N_LANES  : lanes per group
//   ACT_W    : activation width per lane
//   SHIFT_W  : width of the plane index / engine shift
//   DP_RES_W : width of the engine partial-sum result
//   state_t  : scheduler FSM states
package bdp_pkg;

    localparam int N_LANES  = 8;
    localparam int ACT_W    = 8;
    localparam int SHIFT_W  = 3;
    localparam int DP_RES_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/bdp_plane_pick.sv
// Lowest-set-bit encoder over an 8-bit plane mask.
//   mask : remaining planes to issue
//   p    : index of the lowest set bit (0 when mask is empty)
//   last : mask has at most one bit set, so clearing p empties it
module bdp_plane_pick
    import bdp_pkg::*;
(
    input  logic [7:0]         mask,
    output logic [SHIFT_W-1:0] p,
    output logic               last
);

    logic found;

    always_comb begin
        p     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (mask[i] && !found) begin
                p     = SHIFT_W'(i);
                found = 1'b1;
            end
        end
        last = ((mask & (mask - 8'd1)) == '0);
    end

endmodule

// File: rtl/bdp_bitplane_sched.sv
// Bit-plane scheduler for one bit-serial dot-product engine.
// Accepts a group of 8 signed activations and 8 sign-magnitude weights,
// issues one weight magnitude plane per cycle to the engine and accumulates
// the engine's sign-extended partial sums into one signed dot product.
// Build option: ZERO_PLANE_SKIP_EN skips planes in which no lane has a set
// bit (and finishes an all-zero group immediately); without it all W_MAG
// planes are issued in order.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   in_valid/in_ready          group handshake
//   in_act, in_wmag, in_wsign  group activations, magnitudes, signs
//   dp_act, dp_wcol, dp_sign,
//   dp_shift                   engine issue port
//   dp_result                  engine result, DP_LAT cycles after issue
//   out_valid/out_ready        result handshake
//   out_sum                    signed dot product of the group
module bdp_bitplane_sched
    import bdp_pkg::*;
#(
    parameter int W_MAG  = 7,
    parameter int DP_LAT = 2,
    parameter int ACC_W  = 20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_LANES*ACT_W-1:0]   in_act,
    input  logic [N_LANES*W_MAG-1:0]   in_wmag,
    input  logic [N_LANES-1:0]         in_wsign,
    output logic [N_LANES*ACT_W-1:0]   dp_act,
    output logic [N_LANES-1:0]         dp_wcol,
    output logic [N_LANES-1:0]         dp_sign,
    output logic [SHIFT_W-1:0]         dp_shift,
    input  logic [DP_RES_W-1:0]        dp_result,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ACC_W-1:0]           out_sum
);

    state_t                     state_q, state_d;
    logic [N_LANES*ACT_W-1:0]   act_q;
    logic [N_LANES*W_MAG-1:0]   mag_q;
    logic [N_LANES-1:0]         sign_q;
    logic [W_MAG-1:0]           mask_q, mask_d, accept_mask, pick_onehot;
    logic [DP_LAT-1:0]          tag_q, tag_d;
    logic [ACC_W-1:0]           acc_q;
    logic                       accept, issue, tag_head;
    logic [SHIFT_W-1:0]         pick_p;
    logic                       pick_last;
    logic [7:0]                 lane_mag;

`ifdef ZERO_PLANE_SKIP_EN
    always_comb begin
        accept_mask = '0;
        for (int unsigned i = 0; i < N_LANES; i++) begin
            accept_mask = accept_mask | in_wmag[i*W_MAG +: W_MAG];
        end
    end
`else
    // Every plane is issued; the lowest-set-bit walk then yields 0..W_MAG-1.
    assign accept_mask = '1;
`endif

    bdp_plane_pick u_pick (
        .mask (8'(mask_q)),
        .p    (pick_p),
        .last (pick_last)
    );

    assign pick_onehot = W_MAG'(8'd1 << pick_p);
    assign tag_head    = tag_q[DP_LAT-1];

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        accept  = 1'b0;
        issue   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    mask_d  = accept_mask;
`ifdef ZERO_PLANE_SKIP_EN
                    state_d = (accept_mask == '0) ? ST_DONE : ST_ISSUE;
`else
                    state_d = ST_ISSUE;
`endif
                end
            end
            ST_ISSUE: begin
                issue  = 1'b1;
                mask_d = mask_q & ~pick_onehot;
                if (pick_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leave on the edge that lands the final add, so DONE shows
                // the complete sum in its first cycle.
                if (tag_d == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        tag_d = (tag_q << 1) | DP_LAT'(issue);
    end

    always_comb begin
        dp_wcol  = '0;
        dp_sign  = '0;
        dp_shift = '0;
        lane_mag = '0;
        if (issue) begin
            for (int unsigned i = 0; i < N_LANES; i++) begin
                lane_mag   = 8'(mag_q[i*W_MAG +: W_MAG]);
                dp_wcol[i] = lane_mag[pick_p];
            end
            dp_sign  = sign_q;
            dp_shift = pick_p;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            act_q   <= '0;
            mag_q   <= '0;
            sign_q  <= '0;
            mask_q  <= '0;
            tag_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            tag_q   <= tag_d;
            if (accept) begin
                act_q  <= in_act;
                mag_q  <= in_wmag;
                sign_q <= in_wsign;
                acc_q  <= '0;
            end else if (tag_head && (state_q == ST_ISSUE || state_q == ST_DRAIN)) begin
                acc_q <= acc_q + {{(ACC_W-DP_RES_W){dp_result[DP_RES_W-1]}}, dp_result};
            end
        end
    end

    assign dp_act    = act_q;
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_sum   = acc_q;

endmodule

// File: tb/tb_bdp_bitplane_sched.sv
module tb_bdp_bitplane_sched;

    localparam int W_MAG  = 7;
    localparam int DP_LAT = 2;
    localparam int ACC_W  = 20;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [63:0]            in_act = '0;
    logic [8*W_MAG-1:0]     in_wmag = '0;
    logic [7:0]             in_wsign = '0;
    logic [63:0]            dp_act;
    logic [7:0]             dp_wcol;
    logic [7:0]             dp_sign;
    logic [2:0]             dp_shift;
    logic [15:0]            dp_result = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [ACC_W-1:0]       out_sum;

    bdp_bitplane_sched #(
        .W_MAG  (W_MAG),
        .DP_LAT (DP_LAT),
        .ACC_W  (ACC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_act    (in_act),
        .in_wmag   (in_wmag),
        .in_wsign  (in_wsign),
        .dp_act    (dp_act),
        .dp_wcol   (dp_wcol),
        .dp_sign   (dp_sign),
        .dp_shift  (dp_shift),
        .dp_result (dp_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int hold  = 0;
    bit seen  = 1'b0;

    int exp_sum_q[$];
    int exp_lat_q[$];
    int acc_cyc_q[$];

    int   g_act[8];
    int   g_mag[8];
    logic [7:0] g_sgn;

    logic [15:0] eng_hist[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"},  longint'(in_ready), 1);
        chk({tag, "_out_valid"}, longint'(out_valid), 0);
        chk({tag, "_out_sum"},   longint'(out_sum), 0);
        chk({tag, "_dp_wcol"},   longint'(dp_wcol), 0);
        chk({tag, "_dp_sign"},   longint'(dp_sign), 0);
        chk({tag, "_dp_shift"},  longint'(dp_shift), 0);
        chk({tag, "_dp_act"},    longint'(dp_act), 0);
    endtask

    // Engine model: a true signed bit-serial dot product shifted by the plane
    // index, returned DP_LAT cycles later. While the scheduler is idle or
    // holding a result the engine bus carries junk that must never be summed.
    always @(negedge clk) begin
        int v;
        v = 0;
        if (in_ready || out_valid) begin
            v = int'($urandom);
        end else begin
            for (int i = 0; i < 8; i++) begin
                int a;
                a = int'($signed(dp_act[8*i +: 8]));
                if (dp_wcol[i]) v += dp_sign[i] ? -a : a;
            end
            v = v << dp_shift;
        end
        eng_hist.push_front(16'(v));
        if (eng_hist.size() > DP_LAT + 1) void'(eng_hist.pop_back());
        if (eng_hist.size() > DP_LAT) dp_result = eng_hist[DP_LAT];
        else dp_result = 16'($urandom);
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (hold > 0) begin
                out_ready = 1'b0;
                hold--;
            end else begin
                out_ready = ($urandom_range(3) != 0);
            end
        end
    end

    // Result monitor: first sight of out_valid checks latency, every valid
    // cycle checks the held sum, and the handshake retires the entry.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_sum_q.size() == 0) begin
                chk("spurious_out_valid", longint'(out_valid), 0);
            end else begin
                if (!seen) begin
                    chk("latency", cyc - acc_cyc_q[0], exp_lat_q[0]);
                    seen = 1'b1;
                end
                chk("out_sum", longint'($signed(out_sum)), exp_sum_q[0]);
                chk("in_ready_in_done", longint'(in_ready), 0);
                if (out_ready) begin
                    void'(exp_sum_q.pop_front());
                    void'(exp_lat_q.pop_front());
                    void'(acc_cyc_q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic send();
        int   s;
        int   n;
        int   lat;
        bit   ok;
        logic [7:0] ormask;
        s = 0;
        ormask = '0;
        for (int i = 0; i < 8; i++) begin
            s += g_act[i] * (g_sgn[i] ? -g_mag[i] : g_mag[i]);
            ormask |= 8'(g_mag[i]);
        end
`ifdef ZERO_PLANE_SKIP_EN
        n = $countones(ormask);
`else
        n = W_MAG;
`endif
        lat = (n == 0) ? 1 : n + DP_LAT + 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            in_act[8*i +: 8]         = 8'(g_act[i]);
            in_wmag[W_MAG*i +: W_MAG] = W_MAG'(g_mag[i]);
        end
        in_wsign = g_sgn;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                exp_sum_q.push_back(s);
                exp_lat_q.push_back(lat);
                acc_cyc_q.push_back(cyc);
            end
        end
        if (!ok) chk("accept_timeout", longint'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_act   = {$urandom, $urandom};
        in_wsign = 8'($urandom);
    endtask

    task automatic set_uniform(input int a, input int m, input logic [7:0] sg);
        for (int i = 0; i < 8; i++) begin
            g_act[i] = a;
            g_mag[i] = m;
        end
        g_sgn = sg;
    endtask

    // Magnitudes stay below 64 so every shifted plane term fits the engine's
    // 16-bit signed result; the accumulator still exceeds 16 bits.
    task automatic set_random();
        int pm;
        pm = $urandom_range(3) == 0 ? int'($urandom_range(63)) : 63;
        for (int i = 0; i < 8; i++) begin
            g_act[i] = int'($urandom_range(254)) - 127;
            g_mag[i] = int'($urandom_range(63)) & pm;
        end
        g_sgn = 8'($urandom);
    endtask

    task automatic wait_empty();
        for (int k = 0; k < 400 && exp_sum_q.size() != 0; k++) @(negedge clk);
        if (exp_sum_q.size() != 0) chk("drain_timeout", exp_sum_q.size(), 0);
    endtask

    initial begin
        bit found;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        set_uniform(1, 3, 8'h00);   send();
        set_uniform(1, 3, 8'hFF);   send();
        set_uniform(1, 3, 8'h0F);   send();
        set_uniform(-5, 0, 8'hA5);  send();
        set_uniform(127, 63, 8'h00); send();
        set_uniform(127, 63, 8'hFF); send();
        set_uniform(-127, 63, 8'h3C); send();
        wait_empty();

        // Backpressure in DONE, then two back-to-back groups.
        hold = 25;
        set_random(); send();
        set_random(); send();
        set_random(); send();
        wait_empty();

        // Reset in the middle of issuing a five-plane group.
        hold = 0;
        set_uniform(3, 31, 8'h00);
        send();
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            if (dp_shift == 3'd2 && !in_ready && !out_valid) found = 1'b1;
        end
        if (!found) chk("reach_plane2", longint'(dp_shift), 2);
        rst = 1'b1;
        #2;
        check_reset_vals("mid_reset");
        exp_sum_q.delete();
        exp_lat_q.delete();
        acc_cyc_q.delete();
        seen = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_uniform(2, 5, 8'h81);
        send();
        wait_empty();

        for (int g = 0; g < 40; g++) begin
            set_random();
            send();
            if ($urandom_range(3) == 0) wait_empty();
        end
        wait_empty();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
